gt_serial_cmp: RTL
==================

Name: gt_serial_cmp

Overview:
Sequential N-bit unsigned magnitude comparator. It is built on the existing 2-bit greater-than stage and feeds that stage one operand pair per cycle.
- Operands are latched on a start handshake and scanned MSB-first, 2 bits per cycle.
- Comparison terminates early on the first unequal slice.
- Produces registered one-hot gt/eq/lt results and a one-cycle done tick, for use by downstream control logic (max/min selection, sort steps).

Parameters:
N, 8, operand width in bits; must be even and >= 2; number of slices is N/2

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a comparison; accepted only when ready=1
a  input  N  unsigned operand A, sampled on accepted start
b  input  N  unsigned operand B, sampled on accepted start
ready  output  1  1 in idle state only; start is accepted when start=1 and ready=1
done_tick  output  1  one-cycle pulse when a result becomes valid
gt  output  1  registered result a>b, valid from done_tick until next accepted start
eq  output  1  registered result a==b, same validity
lt  output  1  registered result a<b, same validity

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- FSM states: IDLE, COMP, DONE.
- Reset values:
  - state=IDLE, ready=1, done_tick=0.
  - gt=eq=lt=0.
  - Shift registers and slice counter are 0.
- IDLE:
  - ready=1.
  - On start=1: load a_reg<=a, b_reg<=b and slice counter<=N/2-1; clear gt/eq/lt to 0; go to COMP.
  - With start=0, stay in IDLE and hold the results.
- COMP, one slice per cycle:
  - a_hi=a_reg[N-1:N-2], b_hi=b_reg[N-1:N-2].
  - gt_s=gt_2(a_hi,b_hi) and lt_s=gt_2(b_hi,a_hi).
  - If gt_s=1: gt<=1, go to DONE.
  - Else if lt_s=1: lt<=1, go to DONE.
  - Else if counter==0: eq<=1, go to DONE.
  - Else: shift a_reg and b_reg left by 2 (zero fill), decrement counter, stay in COMP.
- DONE: done_tick=1 for exactly this one cycle; unconditionally return to IDLE.
- ready and done_tick are Moore outputs decoded from the state register.
- Latency (start accepted at cycle 0, deciding slice index i, 0=MSB pair):
  - COMP occupies cycles 1..i+1.
  - done_tick is high in cycle i+2.
  - ready returns in cycle i+3.
  - Worst case (equal operands) is done_tick at N/2+1; for N=8 that is cycle 5.
- Exactly one of gt/eq/lt is 1 after a completed comparison. All three are 0 after reset and while a comparison is in flight.
- start while not in IDLE (COMP or DONE) is ignored; no queuing.
- Changes on a/b after the load cycle have no effect.
- reset asserted in any state returns to IDLE on the next edge with all outputs at reset values. No done_tick is generated for an aborted comparison.
- The counter width is clog2(N/2), minimum 1 bit. There is no wrap-around: the counter never decrements below 0.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=2'b00, ST_COMP=2'b01, ST_DONE=2'b10;
  - SLICE_W=2.
- Sub-module: reuse the existing gt_2, instantiated twice (operands swapped for lt_s).
  - No new sub-module is needed.
  - The FSM, shift registers and counter stay in gt_serial_cmp.

Test Plan:
- Reset then idle, N=8 -> ready=1, done_tick=0, gt=eq=lt=0; holding start=0 for 10 cycles changes nothing.
- a=8'hC5, b=8'h35, start at cycle 0 -> slice 0 decides (11>00); done_tick high only at cycle 2, gt=1, eq=lt=0; ready=1 at cycle 3.
- a=8'h40, b=8'h7F -> slice 0 equal, slice 1 00<11; done_tick at cycle 3, lt=1.
- a=8'h5A, b=8'h5A -> all slices equal; done_tick at cycle 5, eq=1; results held through 5 further idle cycles.
- Start with a=8'h12, b=8'h13, then change a/b to 8'hFF/8'h00 and hold start=1 during cycles 1..4 -> the changes and start are ignored; done_tick at cycle 5 with lt=1; a new comparison is accepted only at cycle 6.
- Start with a=8'h00, b=8'h00, assert reset at cycle 2 -> cycle 3 shows ready=1, gt=eq=lt=0; no done_tick ever appears for that request.

Source files
------------

// File: rtl/gt_serial_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: state encoding and slice geometry.
package gt_serial_cmp_pkg;

    // Bits consumed per comparison step (width of the gt_2 stage).
    localparam int unsigned SLICE_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_COMP = 2'b01;
    localparam state_t ST_DONE = 2'b10;

    // Slice counter width: clog2(number of slices), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned slices;
        slices = n / SLICE_W;
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/gt_serial_cmp_gt_2.sv
// Existing 2-bit unsigned greater-than stage: gt = (a > b), purely combinational.
module gt_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);

    // Sum-of-products form of a > b for 2-bit operands.
    always_comb begin
        gt = (a[1] & ~b[1])
           | (a[0] & ~b[1] & ~b[0])
           | (a[1] &  a[0] & ~b[0]);
    end

endmodule

// File: rtl/gt_serial_cmp.sv
// Sequential N-bit unsigned magnitude comparator: scans operands MSB-first, two bits per
// cycle through a shared gt_2 stage, stops at the first unequal slice and reports one-hot
// gt/eq/lt with a single-cycle done_tick.
module gt_serial_cmp
    import gt_serial_cmp_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int unsigned SLICES = N / SLICE_W;
    localparam int unsigned CNT_W  = cnt_width(N);

    state_t             state_reg;
    state_t             state_next;
    logic [N-1:0]       a_reg;
    logic [N-1:0]       b_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [SLICE_W-1:0] a_hi;
    logic [SLICE_W-1:0] b_hi;
    logic               gt_s;
    logic               lt_s;
    logic               last_slice;

    assign a_hi       = a_reg[N-1 -: SLICE_W];
    assign b_hi       = b_reg[N-1 -: SLICE_W];
    assign last_slice = (cnt_reg == '0);

    // Same stage twice; swapping operands yields the less-than decision.
    gt_2 u_gt_ab (
        .a  (a_hi),
        .b  (b_hi),
        .gt (gt_s)
    );

    gt_2 u_gt_ba (
        .a  (b_hi),
        .b  (a_hi),
        .gt (lt_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: leave COMP on the first unequal slice or after the last one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_COMP;
                end
            end
            ST_COMP: begin
                if (gt_s || lt_s || last_slice) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state_reg)
            ST_IDLE: ready     = 1'b1;
            ST_DONE: done_tick = 1'b1;
            default: ;
        endcase
    end

    // Operand shift registers, slice counter and result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            cnt_reg <= '0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        cnt_reg <= CNT_W'(SLICES - 1);
                        gt      <= 1'b0;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                    end
                end
                ST_COMP: begin
                    if (gt_s) begin
                        gt <= 1'b1;
                    end else if (lt_s) begin
                        lt <= 1'b1;
                    end else if (last_slice) begin
                        eq <= 1'b1;
                    end else begin
                        a_reg   <= a_reg << SLICE_W;
                        b_reg   <= b_reg << SLICE_W;
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
